// File: rtl/conway_grid_sched.sv
// rtl/conway_grid_sched.sv - Game-of-Life generation sequencer feeding a 2-stage cell evaluator
//
// Holds the grid in two bit buffers (current/next). A sweep walks the current
// buffer one cell per cycle in row-major order and drives each 3x3
// neighbourhood to the evaluator. The evaluator's results are written into the
// next buffer two cycles later. The buffers are swapped at the end of the
// generation.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           run one generation (taken only when idle)
//   busy            high while sweeping, draining or swapping
//   done            one-cycle pulse when the new generation is readable
//   gen_count       generations completed (16-bit, wraps)
//   live_count      live cells in the latest generation
//   wr_en/wr_row/wr_data   host row write into the current buffer (idle only)
//   rd_row/rd_data  combinational row readback from the current buffer
//   eval_cells      to evaluator: [7:0] neighbours of the scan cell,
//                   [8] centre of the previous scan cell
//   eval_state      evaluator result, two cycles after the neighbours
//
// Build option: define CONWAY_WRAP_EN for a toroidal grid; otherwise the
// cells beyond the border read as dead.

module conway_grid_sched #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic [15:0]                          gen_count,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]    live_count,
    input  logic                                 wr_en,
    input  logic [$clog2(HEIGHT)-1:0]            wr_row,
    input  logic [WIDTH-1:0]                     wr_data,
    input  logic [$clog2(HEIGHT)-1:0]            rd_row,
    output logic [WIDTH-1:0]                     rd_data,
    output logic [8:0]                           eval_cells,
    input  logic                                 eval_state
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int LW = $clog2(WIDTH*HEIGHT+1);

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);
    localparam logic [YW:0]   H_LIM = (YW+1)'(HEIGHT);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, SWAP} state_t;

    state_t state, state_nx;

    // grid[sel][row][col]; cur_sel picks the buffer the host and the sweep read
    logic [WIDTH-1:0] grid [2][HEIGHT];
    logic             cur_sel;
    logic             nxt_sel;

    logic [XW-1:0]    sx;
    logic [YW-1:0]    sy;
    logic             last_x;
    logic             last_y;
    logic             scan_last;
    logic             drain_cnt;
    logic             start_ok;

    // centre of the cell issued last cycle (evaluator applies it one edge late)
    logic             ctr_d;

    // result address pipeline: stage 1 = issued last cycle, stage 2 = two ago
    logic             v1, v2;
    logic [XW-1:0]    a1x, a2x;
    logic [YW-1:0]    a1y, a2y;

    logic [LW-1:0]    live_acc;

    // neighbourhood fetch
    logic [XW-1:0]    xl, xr;
    logic [YW-1:0]    yu, yd;
    logic [WIDTH-1:0] row_n, row_c, row_s;
    logic             has_l, has_r;
    logic [7:0]       nb;

    assign nxt_sel   = ~cur_sel;
    assign last_x    = (sx == X_MAX);
    assign last_y    = (sy == Y_MAX);
    assign scan_last = last_x && last_y;
    assign start_ok  = (state == IDLE) && start;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SWEEP;
                end
            end
            SWEEP: begin
                busy = 1'b1;
                if (scan_last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt) begin
                    state_nx = SWAP;
                end
            end
            SWAP: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ---------------- scan, pipeline, status ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx         <= '0;
            sy         <= '0;
            drain_cnt  <= 1'b0;
            ctr_d      <= 1'b0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            a1x        <= '0;
            a1y        <= '0;
            a2x        <= '0;
            a2y        <= '0;
            live_acc   <= '0;
            cur_sel    <= 1'b0;
            gen_count  <= '0;
            live_count <= '0;
            done       <= 1'b0;
        end else begin
            if (start_ok) begin
                sx <= '0;
                sy <= '0;
            end else if (state == SWEEP) begin
                if (last_x) begin
                    sx <= '0;
                    sy <= last_y ? '0 : sy + YW'(1);
                end else begin
                    sx <= sx + XW'(1);
                end
            end

            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            ctr_d     <= (state == SWEEP) ? row_c[sx] : 1'b0;

            v1  <= (state == SWEEP);
            a1x <= sx;
            a1y <= sy;
            v2  <= v1;
            a2x <= a1x;
            a2y <= a1y;

            if (start_ok) begin
                live_acc <= '0;
            end else if (v2) begin
                live_acc <= live_acc + LW'(eval_state);
            end

            if (state == SWAP) begin
                cur_sel    <= nxt_sel;
                gen_count  <= gen_count + 16'd1;
                live_count <= live_acc;
            end

            done <= (state == SWAP);
        end
    end

    // ---------------- grid buffers ----------------
    // Host writes (idle only) and result captures (sweep/drain only) never
    // overlap in time and target different buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < HEIGHT; r++) begin
                    grid[b][r] <= '0;
                end
            end
        end else begin
            if ((state == IDLE) && wr_en && ({1'b0, wr_row} < H_LIM)) begin
                grid[cur_sel][wr_row] <= wr_data;
            end
            if (v2) begin
                grid[nxt_sel][a2y][a2x] <= eval_state;
            end
        end
    end

    assign rd_data = ({1'b0, rd_row} < H_LIM) ? grid[cur_sel][rd_row] : '0;

    // ---------------- neighbourhood ----------------
    always_comb begin
        xl = (sx == '0)  ? X_MAX : sx - XW'(1);
        xr = last_x      ? '0    : sx + XW'(1);
        yu = (sy == '0)  ? Y_MAX : sy - YW'(1);
        yd = last_y      ? '0    : sy + YW'(1);

        row_c = grid[cur_sel][sy];
`ifdef CONWAY_WRAP_EN
        row_n = grid[cur_sel][yu];
        row_s = grid[cur_sel][yd];
        has_l = 1'b1;
        has_r = 1'b1;
`else
        // dead border: wrapped rows/columns are masked off
        row_n = (sy == '0) ? '0 : grid[cur_sel][yu];
        row_s = last_y     ? '0 : grid[cur_sel][yd];
        has_l = (sx != '0);
        has_r = !last_x;
`endif

        nb[0] = has_l & row_n[xl];
        nb[1] = row_n[sx];
        nb[2] = has_r & row_n[xr];
        nb[3] = has_l & row_c[xl];
        nb[4] = has_r & row_c[xr];
        nb[5] = has_l & row_s[xl];
        nb[6] = row_s[sx];
        nb[7] = has_r & row_s[xr];
    end

    assign eval_cells[7:0] = (state == SWEEP) ? nb : 8'd0;
    assign eval_cells[8]   = ((state == SWEEP) || (state == DRAIN)) ? ctr_d : 1'b0;

endmodule

// File: doc/conway_grid_sched.md
# conway_grid_sched

Generation sequencer for the Game-of-Life cell evaluator. Holds a WIDTH×HEIGHT grid in two internal bit buffers (current/next), scans the current buffer one cell per cycle, and presents each 3×3 neighbourhood to an external 2-stage cell evaluator. It writes the returned states into the next buffer and swaps buffers at the end of each generation. It sits between the host load/readback logic and the evaluator instance.

## Interface
- WIDTH, 8, grid columns (≥3)
- HEIGHT, 8, grid rows (≥3)
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  run one generation; sampled only in IDLE
- busy  out  1  high in SWEEP, DRAIN, SWAP
- done  out  1  one-cycle pulse; new generation visible on rd_data
- gen_count  out  16  generations completed, wraps 0xFFFF→0
- live_count  out  $clog2(WIDTH*HEIGHT+1)  live cells in the latest generation
- wr_en  in  1  write a row into the current buffer; ignored while busy
- wr_row  in  $clog2(HEIGHT)  row index; out-of-range writes are ignored
- wr_data  in  WIDTH  row bits, bit x = column x
- rd_row  in  $clog2(HEIGHT)  readback row
- rd_data  out  WIDTH  current-buffer row, combinational from rd_row; 0 if out of range
- eval_cells  out  9  to evaluator: [7:0] neighbours, [8] centre
- eval_state  in  1  from evaluator

## Operation
- Neighbour order in eval_cells[7:0]: 0 NW, 1 N, 2 NE, 3 W, 4 E, 5 SW, 6 S, 7 SE. (x-1, y-1) is NW.
- Evaluator skew: the evaluator registers the neighbour sum at edge k and applies the centre at edge k+1.
  - eval_cells[8] carries the centre of the cell whose neighbours were driven in the previous cycle.
  - eval_cells[7:0] carries the neighbours of the cell at the current scan position.
  - Both fields are combinational from the scan counters, the current buffer and a 1-bit centre delay register.
- FSM states: IDLE, SWEEP, DRAIN, SWAP.
  - IDLE → SWEEP on start. Scan position resets to (0,0).
  - SWEEP lasts N = WIDTH*HEIGHT cycles and issues one cell per cycle in row-major order (x fastest). It → DRAIN after the cell at (WIDTH-1, HEIGHT-1) is issued.
  - DRAIN lasts 2 cycles, then → SWAP.
  - SWAP lasts 1 cycle. It flips the current/next select, increments gen_count, loads live_count from the running accumulator, and → IDLE.
- Result capture: the cell issued in cycle t is written into the next buffer at the edge ending cycle t+2. Its address comes from a 2-deep address/valid shift register. The same edge adds eval_state to the live accumulator, which is cleared when SWEEP is entered.
- eval_cells is 0 in IDLE. In DRAIN cycle 1, eval_cells[8] carries the last centre.
- Writes: a wr_en in IDLE updates the current buffer at that edge. If wr_en and start coincide, the write lands first and the sweep sees it. wr_en in any other state is dropped.
- start while busy is ignored and not queued.
- Reset state:
  - Both buffers cleared; current select 0.
  - FSM in IDLE.
  - busy=0, done=0, gen_count=0, live_count=0, eval_cells=0.
  - Reset mid-generation abandons the generation; no partial swap.

## Timing
- start is sampled at edge E0. SWEEP runs in cycles 1..N, DRAIN in N+1..N+2, SWAP in N+3.
- done is high in cycle N+4, the first IDLE cycle, when rd_data already shows the new generation. For 8×8, done arrives 68 cycles after E0.
- Back-to-back: start may be asserted during the done cycle and is accepted.
- busy rises in cycle 1 and falls after SWAP.
- gen_count and live_count change at the SWAP→IDLE edge.

## Configuration
- CONWAY_WRAP_EN defined: toroidal grid. Neighbour coordinates wrap modulo WIDTH and HEIGHT.
- CONWAY_WRAP_EN undefined: out-of-grid neighbours read as 0 (dead border).
- Interface and timing are identical in both builds.

## Test plan
- Blinker on 8×8: row 3 columns 2–4 set, start → after done, column 3 rows 2–4 set. live_count=3, gen_count=1. A second start restores the original; gen_count=2.
- Block still life: 2×2 at (1,1) → unchanged after 4 generations, live_count=4 each time.
- Edge behaviour: horizontal blinker at row 0 columns 3–5.
  - With CONWAY_WRAP_EN: after one generation, column 4 rows 7, 0, 1 are set.
  - Without CONWAY_WRAP_EN: only rows 0–1 of column 4 are set, live_count=2.
- Latency and handshake: for 8×8, count cycles from start to done (expect 68). busy is high for exactly 67 cycles. start and wr_en pulsed mid-SWEEP have no effect on the result or on gen_count.
- Reset mid-SWEEP: load the blinker, start, assert rst at SWEEP cycle 20 → all rd_data rows 0, gen_count=0, busy=0, no done pulse.
- Write+start same cycle: empty grid, wr_row=2 and wr_data=0x1C together with start → the result equals the blinker's next generation.
